// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB PWM driver: counter width, colour struct,
// bit positions of each channel inside the 24-bit light word, gamma helper.
package rgb_pwm_pkg;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    // Square-law gamma: (v*v)>>8, so 0x80->0x40 and 0xFF->0xFE.
    function automatic logic [7:0] gamma8(input logic [7:0] v);
        logic [15:0] sq;
        sq = 16'(v) * 16'(v);
        return sq[15:8];
    endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Colour handshake between the lights selector (master) and the driver (slave).
interface rgb_pwm_driver_if;
    import rgb_pwm_pkg::*;

    logic [3*CNT_W-1:0] light;
    logic               light_valid;
    logic               light_ready;

    modport master (output light, output light_valid, input light_ready);
    modport slave  (input light, input light_valid, output light_ready);

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: active duty register, optional gamma stage, registered
// compare against the shared counter. Gamma enabled by RGB_PWM_GAMMA_EN.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic [CNT_W-1:0] cnt,
    input  logic             enable,
    output logic             pwm
);

    logic [CNT_W-1:0] w_duty_next;
    logic [CNT_W-1:0] r_duty;
    logic             r_pwm;

`ifdef RGB_PWM_GAMMA_EN
    assign w_duty_next = gamma8(value);
`else
    assign w_duty_next = value;
`endif

    // Active duty only changes when the top signals a transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_duty <= '0;
        else if (load) r_duty <= w_duty_next;
    end

    // Registered compare; forced low while the driver is stopped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pwm <= 1'b0;
        else      r_pwm <= enable && (cnt < r_duty);
    end

    assign pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM driver: prescaled 8-bit counter, single-entry pending colour
// buffer applied at period wrap (or immediately while disabled), three
// pwm_channel instances. Gamma correction enabled by RGB_PWM_GAMMA_EN.
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESC = 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    rgb_pwm_driver_if.slave     lif,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b,
    output logic                period_end
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESC - 1);

    logic [15:0]      r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_period_end;
    rgb_t             r_pending;
    logic             r_pending_full;

    logic w_tick;
    logic w_wrap;
    logic w_load;
    logic w_accept;

    assign w_tick   = enable && (r_presc == PRESC_MAX);
    assign w_wrap   = w_tick && (r_cnt == '1);
    // Transfer at the wrap, or straight away while stopped.
    assign w_load   = r_pending_full && (w_wrap || !enable);
    assign w_accept = lif.light_valid && !r_pending_full;

    // Prescaler counts 0..PRESC-1 and is parked at 0 while stopped.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst)                   r_presc <= '0;
        else if (!enable || w_tick) r_presc <= '0;
        else                        r_presc <= r_presc + 16'd1;
    end

    // PWM step counter, free-wrapping 255->0 on ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_cnt <= '0;
        else if (!enable) r_cnt <= '0;
        else if (w_tick)  r_cnt <= r_cnt + CNT_W'(1);
    end

    // One-cycle pulse after each wrap edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_period_end <= 1'b0;
        else      r_period_end <= w_wrap;
    end

    // Single-entry pending buffer; accept and transfer are mutually exclusive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending      <= '0;
            r_pending_full <= 1'b0;
        end else if (w_load) begin
            r_pending_full <= 1'b0;
        end else if (w_accept) begin
            r_pending.r    <= lif.light[R_HI:R_LO];
            r_pending.g    <= lif.light[G_HI:G_LO];
            r_pending.b    <= lif.light[B_HI:B_LO];
            r_pending_full <= 1'b1;
        end
    end

    assign lif.light_ready = !r_pending_full;
    assign period_end      = r_period_end;

    pwm_channel u_ch_r (
        .clk(clk), .rst(rst), .load(w_load), .value(r_pending.r),
        .cnt(r_cnt), .enable(enable), .pwm(pwm_r)
    );

    pwm_channel u_ch_g (
        .clk(clk), .rst(rst), .load(w_load), .value(r_pending.g),
        .cnt(r_cnt), .enable(enable), .pwm(pwm_g)
    );

    pwm_channel u_ch_b (
        .clk(clk), .rst(rst), .load(w_load), .value(r_pending.b),
        .cnt(r_cnt), .enable(enable), .pwm(pwm_b)
    );

endmodule
